// File: rtl/seq_throughout_monitor.sv
// seq_throughout_monitor: synthesizable checker for
//   start |=> exp throughout (x ##GAP y)
// One attempt enters the live pipe per sampled start; each pipe stage checks
// its slice of the sequence, so overlapping attempts are tracked in parallel.
// Optional feature: define SEQ_MON_STICKY_EN to build the err_sticky latch.

// Per-stage check. The stage's sequence term is x (first), y (last) or a
// constant 1 (middle), so one body covers all stage kinds. exp is tested
// first so its code wins.
module seq_tm_stage #(
  parameter logic [1:0] TERM_CODE = 2'b00
) (
  input  logic       act,
  input  logic       exp,
  input  logic       term,
  output logic       ok,
  output logic       fail,
  output logic [1:0] code
);
  // Survive when both conditions hold; otherwise report the first missing one.
  always_comb begin
    ok   = act & exp & term;
    fail = act & ~(exp & term);
    code = 2'b00;
    if (!exp)       code = 2'b10;
    else if (!term) code = TERM_CODE;
  end
endmodule

module seq_throughout_monitor #(
  parameter int GAP   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             exp,
  input  logic             x,
  input  logic             y,
  input  logic             clr,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky
);
  localparam int PW = $clog2(GAP + 2);   // holds a popcount of 0..GAP+1
  localparam int SW = CNT_W + PW;        // fail sum can never overflow this
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [SW-1:0]    SMAX = {{PW{1'b0}}, CMAX};

  logic [GAP:0]      live;
  logic [GAP:0]      term;
  logic [GAP:0]      ok;
  logic [GAP:0]      sfail;
  logic [GAP:0][1:0] scode;

  logic              fail_any;
  logic [1:0]        code_sel;
  logic [PW-1:0]     pop;
  logic [SW-1:0]     fail_sum;
  logic [CNT_W-1:0]  pass_cnt_nxt;
  logic [CNT_W-1:0]  fail_cnt_nxt;

  genvar k;
  generate
    for (k = 0; k <= GAP; k++) begin : g_stg
      assign term[k] = (k == 0) ? x : ((k == GAP) ? y : 1'b1);
      seq_tm_stage #(
        .TERM_CODE((k == 0) ? 2'b01 : 2'b11)
      ) u_stg (
        .act  (live[k]),
        .exp  (exp),
        .term (term[k]),
        .ok   (ok[k]),
        .fail (sfail[k]),
        .code (scode[k])
      );
    end
  endgenerate

  // Combine stage verdicts: the highest failing stage is the oldest attempt.
  always_comb begin
    fail_any = |sfail;
    code_sel = 2'b00;
    pop      = '0;
    for (int i = 0; i <= GAP; i++) begin
      if (sfail[i]) code_sel = scode[i];
      pop = pop + PW'(sfail[i]);
    end
    fail_sum     = SW'(fail_cnt) + SW'(pop);
    fail_cnt_nxt = (fail_sum > SMAX) ? CMAX : fail_sum[CNT_W-1:0];
    pass_cnt_nxt = (ok[GAP] && pass_cnt != CMAX) ? pass_cnt + 1'b1 : pass_cnt;
  end

  // Live-attempt pipe: new attempt at stage 0, survivors advance one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= '0;
    else        live <= {ok[GAP-1:0], start};
  end

  // Registered verdict pulses and saturating counters; clr beats increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'b00;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      pass      <= ok[GAP];
      fail      <= fail_any;
      fail_code <= fail_any ? code_sel : 2'b00;
      if (clr) begin
        pass_cnt <= '0;
        fail_cnt <= '0;
      end else begin
        pass_cnt <= pass_cnt_nxt;
        fail_cnt <= fail_cnt_nxt;
      end
    end
  end

`ifdef SEQ_MON_STICKY_EN
  // Sticky error: set with the fail pulse, held until clr or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_sticky <= 1'b0;
    else if (clr)      err_sticky <= 1'b0;
    else if (fail_any) err_sticky <= 1'b1;
  end
`else
  assign err_sticky = 1'b0;
`endif

endmodule
